// File: rtl/sa_deskew_quant.sv
// sa_deskew_quant: deskews systolic column partial sums, quantizes rows and writes them back.
module sa_deskew_quant #(
    parameter int N     = 4,
    parameter int PSW   = 32,
    parameter int OW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     num_rows,
    input  logic [4:0]      shift,
    input  logic [1:0]      act_mode,
    input  logic [N*PSW-1:0] ps_in,
    input  logic [N-1:0]    ps_valid,
    output logic            wb_we,
    output logic [AW-1:0]   wb_addr,
    output logic [N*OW-1:0] wb_data,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic            err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic signed [PSW:0] QMAX = (PSW+1)'(2**(OW-1)-1);
    localparam logic signed [PSW:0] QMIN = -QMAX - 1;
    state_t            state;
    logic [AW:0]       rows_lat, wr_cnt;
    logic [AW:0]       col_cnt [N];
    logic [4:0]        shift_l;
    logic [1:0]        mode_l;
    logic [N-1:0]      acc, d_v, clip;
    logic [PSW-1:0]    d_ps [N];
    logic [N*OW-1:0]   lanes, q_data;
    logic              q_valid, q_ovf, aligned, mis, extra, late;
    for (genvar i = 0; i < N; i++) begin : g_col
        localparam int L = N - 1 - i;
        assign acc[i] = ps_valid[i] && state == RUN && col_cnt[i] < rows_lat;
        if (L == 0) begin : g_thru
            assign d_v[i]  = acc[i];
            assign d_ps[i] = ps_in[i*PSW +: PSW];
        end else begin : g_dly
            logic [L-1:0]   sv;
            logic [PSW-1:0] sd [L];
            always_ff @(posedge clk) begin
                if (reset) begin
                    sv <= '0;
                    for (int k = 0; k < L; k++) sd[k] <= '0;
                end else begin
                    sv[0] <= acc[i];
                    sd[0] <= ps_in[i*PSW +: PSW];
                    for (int k = 1; k < L; k++) begin
                        sv[k] <= sv[k-1];
                        sd[k] <= sd[k-1];
                    end
                end
            end
            assign d_v[i]  = sv[L-1];
            assign d_ps[i] = sd[L-1];
        end
    end
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic signed [PSW:0] ext, rnd, q;
        logic                hi, lo;
        logic [OW-1:0]       sat;
        assign ext = {d_ps[i][PSW-1], d_ps[i]};
        assign rnd = shift_l == 5'd0 ? '0 : (PSW+1)'(1) << (shift_l - 5'd1);
        assign q   = (ext + rnd) >>> shift_l;
        assign hi  = q > QMAX;
        assign lo  = q < QMIN;
        assign sat = hi ? QMAX[OW-1:0] : lo ? QMIN[OW-1:0] : q[OW-1:0];
        assign clip[i] = hi | lo;
        assign lanes[i*OW +: OW] = (mode_l == 2'b01 && sat[OW-1]) ? '0 : sat;
    end
    assign aligned = &d_v;
    assign mis     = |d_v && !aligned;
    assign extra   = state != IDLE && |(ps_valid & ~acc);
    assign late    = q_valid && state != RUN;
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_ovf   <= 1'b0;
            q_data  <= '0;
        end else begin
            q_valid <= aligned;
            if (aligned) begin
                q_data <= lanes;
                q_ovf  <= |clip;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
            rows_lat <= '0;
            wr_cnt   <= '0;
            shift_l  <= '0;
            mode_l   <= '0;
            for (int c = 0; c < N; c++) col_cnt[c] <= '0;
        end else begin
            wb_we <= 1'b0;
            done  <= 1'b0;
            err   <= err | mis | extra | late;
            for (int c = 0; c < N; c++) if (acc[c]) col_cnt[c] <= col_cnt[c] + 1'b1;
            case (state)
                IDLE: if (start && num_rows != '0) begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    rows_lat <= num_rows > DEPTH_W ? DEPTH_W : num_rows;
                    shift_l  <= shift;
                    mode_l   <= act_mode;
                    wb_addr  <= '0;
                    wr_cnt   <= '0;
                    overflow <= 1'b0;
                    err      <= 1'b0;
                    for (int c = 0; c < N; c++) col_cnt[c] <= '0;
                end
                RUN: if (q_valid) begin
                    wb_we    <= 1'b1;
                    wb_data  <= q_data;
                    wb_addr  <= wr_cnt[AW-1:0];
                    wr_cnt   <= wr_cnt + 1'b1;
                    overflow <= overflow | q_ovf;
                    if (wr_cnt == rows_lat - 1'b1) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_deskew_quant.sv
// tb_sa_deskew_quant: directed-vector bench for sa_deskew_quant (N=4, PSW=32, OW=8).
module tb_sa_deskew_quant;
    logic        clk = 0, reset = 1, start = 0;
    logic [4:0]  num_rows = '0, shift = '0;
    logic [1:0]  act_mode = '0;
    logic [127:0] ps_in = '0;
    logic [3:0]  ps_valid = '0;
    logic        wb_we, busy, done, overflow, err;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    int n_cmp = 0, n_bad = 0;
    int rd [8][4];
    int wcnt, dcnt, dcyc;
    int wcyc [8];
    logic [3:0]  waddr [8];
    logic [31:0] wdata [8];

    sa_deskew_quant dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .shift(shift),
        .act_mode(act_mode), .ps_in(ps_in), .ps_valid(ps_valid), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done),
        .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_row(input int r, input int a, input int b, input int c, input int d);
        rd[r][0] = a; rd[r][1] = b; rd[r][2] = c; rd[r][3] = d;
    endtask

    task automatic frame(input logic [4:0] nr, input logic [4:0] sh, input logic [1:0] md,
                         input int nsend, input int drop_r, input int drop_c, input int ncyc);
        wcnt = 0; dcnt = 0; dcyc = -1;
        start = 1; num_rows = nr; shift = sh; act_mode = md;
        @(posedge clk); #1;
        start = 0;
        for (int cy = 0; cy < ncyc; cy++) begin
            ps_valid = '0; ps_in = '0;
            for (int c = 0; c < 4; c++) begin
                int r;
                r = cy - c;
                if (r >= 0 && r < nsend && !(r == drop_r && c == drop_c)) begin
                    ps_valid[c] = 1'b1;
                    ps_in[c*32 +: 32] = rd[r][c];
                end
            end
            @(posedge clk); #1;
            if (wb_we && wcnt < 8) begin
                wcyc[wcnt] = cy + 1; waddr[wcnt] = wb_addr; wdata[wcnt] = wb_data;
                wcnt++;
            end
            if (done) begin dcyc = cy + 1; dcnt++; end
        end
        ps_valid = '0; ps_in = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic basic(input string tag);
        set_row(0, 10, 20, 30, 40);
        frame(1, 0, 0, 1, -1, -1, 9);
        chk({tag, "_wcnt"}, wcnt, 1);
        chk({tag, "_wcyc"}, wcyc[0], 5);
        chk({tag, "_addr"}, waddr[0], 0);
        chk({tag, "_data"}, wdata[0], 32'h281E140A);
        chk({tag, "_dcnt"}, dcnt, 1);
        chk({tag, "_dcyc"}, dcyc, 6);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hold"}, wb_data, 32'h281E140A);
    endtask

    initial begin
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        chk("rst_we", wb_we, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_data", wb_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err, 0);

        start = 1; num_rows = 0;
        @(posedge clk); #1;
        start = 0;
        chk("start_zero_ign", busy, 0);

        basic("basic");

        set_row(0, 6, -6, 5, -5);
        frame(1, 2, 2'b00, 1, -1, -1, 9);
        chk("rnd_wcnt", wcnt, 1);
        chk("rnd_data", wdata[0], 32'hFF01FF02);
        frame(1, 2, 2'b01, 1, -1, -1, 9);
        chk("relu_data", wdata[0], 32'h00010002);
        chk("relu_ovf", overflow, 0);

        set_row(0, 300, -300, 127, -128);
        frame(1, 0, 0, 1, -1, -1, 9);
        chk("sat_data", wdata[0], 32'h807F807F);
        chk("sat_ovf", overflow, 1);
        repeat (3) @(posedge clk);
        #1 chk("sat_ovf_sticky", overflow, 1);

        for (int r = 0; r < 5; r++) set_row(r, 4*r+1, 4*r+2, 4*r+3, 4*r+4);
        frame(4, 0, 0, 5, -1, -1, 14);
        chk("str_wcnt", wcnt, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("str_addr%0d", k), waddr[k], k);
            chk($sformatf("str_cyc%0d", k), wcyc[k], 5 + k);
            chk($sformatf("str_data%0d", k), wdata[k],
                {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
        end
        chk("str_dcnt", dcnt, 1);
        chk("str_dcyc", dcyc, 9);
        chk("str_err", err, 1);
        chk("str_ovf_clr", overflow, 0);

        set_row(0, 1, 2, 3, 4);
        frame(1, 0, 0, 1, 0, 2, 10);
        chk("mis_wcnt", wcnt, 0);
        chk("mis_err", err, 1);
        chk("mis_busy", busy, 1);
        do_reset();
        chk("mis_rst_busy", busy, 0);

        set_row(0, 1, 2, 3, 4);
        set_row(1, 5, 6, 7, 8);
        frame(2, 0, 0, 2, -1, -1, 4);
        do_reset();
        chk("mid_busy", busy, 0);
        chk("mid_we", wb_we, 0);
        chk("mid_err", err, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_addr", wb_addr, 0);
        wcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wb_we) wcnt++;
        end
        chk("mid_nowrite", wcnt, 0);

        basic("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
